// File: rtl/rtc_pkg.sv
// Shared types, digit limits and BCD helpers for the time-of-day counter.
// time_valid() is the single range check used for both time and alarm loads.
package rtc_pkg;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t h2;
    bcd_t h1;
    bcd_t m2;
    bcd_t m1;
    bcd_t s2;
    bcd_t s1;
  } rtc_time_t;

  localparam bcd_t SEC_TENS_MAX        = 4'd5;
  localparam bcd_t DIGIT_MAX           = 4'd9;
  localparam bcd_t HOUR_TENS_MAX       = 4'd2;
  localparam bcd_t HOUR_ONES_MAX_AT_20 = 4'd3;

  function automatic logic time_valid(input rtc_time_t t);
    return (t.s1 <= DIGIT_MAX) && (t.s2 <= SEC_TENS_MAX) &&
           (t.m1 <= DIGIT_MAX) && (t.m2 <= SEC_TENS_MAX) &&
           (t.h1 <= DIGIT_MAX) && (t.h2 <= HOUR_TENS_MAX) &&
           !((t.h2 == HOUR_TENS_MAX) && (t.h1 > HOUR_ONES_MAX_AT_20));
  endfunction

  // One-second advance with digit-wise BCD carries; 23:59:59 rolls to 00:00:00.
  function automatic rtc_time_t time_inc(input rtc_time_t t);
    rtc_time_t n;
    n = t;
    if (t.s1 != DIGIT_MAX) begin
      n.s1 = t.s1 + 4'd1;
    end else begin
      n.s1 = 4'd0;
      if (t.s2 != SEC_TENS_MAX) begin
        n.s2 = t.s2 + 4'd1;
      end else begin
        n.s2 = 4'd0;
        if (t.m1 != DIGIT_MAX) begin
          n.m1 = t.m1 + 4'd1;
        end else begin
          n.m1 = 4'd0;
          if (t.m2 != SEC_TENS_MAX) begin
            n.m2 = t.m2 + 4'd1;
          end else begin
            n.m2 = 4'd0;
            if ((t.h2 == HOUR_TENS_MAX) && (t.h1 == HOUR_ONES_MAX_AT_20)) begin
              n.h2 = 4'd0;
              n.h1 = 4'd0;
            end else if (t.h1 == DIGIT_MAX) begin
              n.h2 = t.h2 + 4'd1;
              n.h1 = 4'd0;
            end else begin
              n.h1 = t.h1 + 4'd1;
            end
          end
        end
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/rtc_tick_prescaler.sv
// Divides clk down to a one-cycle tick every TICK_DIV running cycles.
// Holds while run=0; clr restarts the count and suppresses a coincident tick.
module rtc_tick_prescaler #(
  parameter int TICK_DIV = 100000000,
  parameter int CNT_W    = 27
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clr,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_expire;

  assign w_expire = run && (r_cnt == LAST);
  assign tick     = w_expire && !clr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr || w_expire) begin
      r_cnt <= '0;
    end else if (run) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/bcd_rtc_counter.sv
// hh:mm:ss BCD time-of-day counter with load, alarm, day-wrap and 12h/24h display.
// Count is always 24h internally; the 12h view is a zero-latency remap of the hour.
module bcd_rtc_counter
  import rtc_pkg::*;
#(
  parameter int TICK_DIV = 100000000,
  parameter int CNT_W    = 27
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        mode12,
  input  logic        load_valid,
  input  logic [23:0] load_time,
  input  logic        alarm_we,
  input  logic [23:0] alarm_time,
  input  logic        alarm_en,
  output logic [3:0]  s1,
  output logic [3:0]  s2,
  output logic [3:0]  m1,
  output logic [3:0]  m2,
  output logic [3:0]  h1,
  output logic [3:0]  h2,
  output logic        pm,
  output logic        sec_tick,
  output logic        day_wrap,
  output logic        alarm_hit,
  output logic        load_err
);

  rtc_time_t r_time;
  rtc_time_t r_alarm;
  logic      r_sec_tick;
  logic      r_day_wrap;
  logic      r_alarm_hit;
  logic      r_load_err;

  rtc_time_t w_load_time;
  rtc_time_t w_alarm_time;
  rtc_time_t w_next;
  logic      w_load_ok;
  logic      w_alarm_ok;
  logic      w_err;
  logic      w_tick;

  assign w_load_time  = load_time;
  assign w_alarm_time = alarm_time;
  assign w_load_ok    = load_valid && time_valid(w_load_time);
  assign w_alarm_ok   = alarm_we && time_valid(w_alarm_time);
  assign w_err        = (load_valid && !time_valid(w_load_time)) ||
                        (alarm_we && !time_valid(w_alarm_time));
  assign w_next       = time_inc(r_time);

  // An accepted load clears the prescaler, which also swallows any tick due this edge.
  rtc_tick_prescaler #(
    .TICK_DIV(TICK_DIV),
    .CNT_W   (CNT_W)
  ) u_prescaler (
    .clk (clk),
    .rst (rst),
    .run (run),
    .clr (w_load_ok),
    .tick(w_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_time      <= '0;
      r_alarm     <= '0;
      r_sec_tick  <= 1'b0;
      r_day_wrap  <= 1'b0;
      r_alarm_hit <= 1'b0;
      r_load_err  <= 1'b0;
    end else begin
      if (w_load_ok) begin
        r_time <= w_load_time;
      end else if (w_tick) begin
        r_time <= w_next;
      end
      // Alarm match uses the pre-write alarm value when both happen together.
      if (w_alarm_ok) begin
        r_alarm <= w_alarm_time;
      end
      r_sec_tick  <= w_tick;
      r_day_wrap  <= w_tick && (w_next == '0);
      r_alarm_hit <= w_tick && alarm_en && (w_next == r_alarm);
      r_load_err  <= w_err;
    end
  end

  assign s1        = r_time.s1;
  assign s2        = r_time.s2;
  assign m1        = r_time.m1;
  assign m2        = r_time.m2;
  assign sec_tick  = r_sec_tick;
  assign day_wrap  = r_day_wrap;
  assign alarm_hit = r_alarm_hit;
  assign load_err  = r_load_err;

  // 12h remap: 00->12, 13..19->01..07, 20..21->08..09, 22..23->10..11.
  always_comb begin
    h2 = r_time.h2;
    h1 = r_time.h1;
    pm = 1'b0;
    if (mode12) begin
      pm = (r_time.h2 == 4'd2) || ((r_time.h2 == 4'd1) && (r_time.h1 >= 4'd2));
      if ((r_time.h2 == 4'd0) && (r_time.h1 == 4'd0)) begin
        h2 = 4'd1;
        h1 = 4'd2;
      end else if ((r_time.h2 == 4'd1) && (r_time.h1 >= 4'd3)) begin
        h2 = 4'd0;
        h1 = r_time.h1 - 4'd2;
      end else if ((r_time.h2 == 4'd2) && (r_time.h1 <= 4'd1)) begin
        h2 = 4'd0;
        h1 = r_time.h1 + 4'd8;
      end else if (r_time.h2 == 4'd2) begin
        h2 = 4'd1;
        h1 = r_time.h1 - 4'd2;
      end
    end
  end

endmodule
